// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and constants for the run-time clock divider controller.
// Optional feature macro: CLK_DIV_CTRL_DUTY50_EN (see clk_div_core.sv).
package clk_div_ctrl_pkg;

    // Default ratio width; modules carry a DIV_W parameter that mirrors this.
    localparam int DIV_W = 8;

    // Smallest ratio that still produces a toggling output (1 high / 1 low).
    localparam int DIV_MIN = 2;

    typedef logic [DIV_W-1:0] div_t;

    // STOP: output parked low, counter held at 0.
    // RUN : counting with the current ratio.
    // PEND: counting with the current ratio while a new one waits for the boundary.
    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

endpackage

// File: rtl/clk_div_core.sv
// Period counter plus registered divided clock and period tick.
// With CLK_DIV_CTRL_DUTY50_EN defined, odd ratios get an extra negedge
// flop that stretches the high phase by half a clk_in cycle (exact 50%).
module clk_div_core #(
    parameter int DIV_W = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             clk_out,
    output logic             tick_out,
    output logic             wrap
);
    import clk_div_ctrl_pkg::*;

    localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);
    localparam logic [DIV_W:0]   EXT_ONE = (DIV_W+1)'(1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             pos_q, pos_d;
    logic             tick_q, tick_d;
    logic [DIV_W:0]   div_ext;
    logic [DIV_W:0]   hi_lim;
    logic             last;

    assign div_ext = {1'b0, div};

    // Number of counter states during which the posedge term is high.
    // Computed one bit wider so a ratio of 2^DIV_W-1 cannot overflow.
`ifdef CLK_DIV_CTRL_DUTY50_EN
    assign hi_lim = div_ext >> 1;
`else
    assign hi_lim = (div_ext + EXT_ONE) >> 1;
`endif

    // ">=" rather than "==" so a counter that is somehow past the end still wraps.
    assign last = (cnt_q >= (div - CNT_ONE));
    assign wrap = en & last;

    // Next counter value and the posedge high-phase / tick terms.
    always_comb begin
        cnt_d  = cnt_q;
        pos_d  = 1'b0;
        tick_d = 1'b0;
        if (en) begin
            cnt_d  = last ? '0 : (cnt_q + CNT_ONE);
            pos_d  = ({1'b0, cnt_q} < hi_lim);
            tick_d = (cnt_q == '0);
        end else begin
            cnt_d  = '0;
        end
    end

    // Counter and registered outputs; stopping forces everything to 0.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q  <= '0;
            pos_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            tick_q <= tick_d;
        end
    end

    assign tick_out = tick_q;

`ifdef CLK_DIV_CTRL_DUTY50_EN
    logic neg_q;

    // Half-cycle delayed copy of the high phase, only for odd ratios.
    always_ff @(negedge clk_in) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q & div[0];
        end
    end

    // Rising edge comes from pos_q, falling edge from neg_q: no glitch since
    // neg_q only ever extends a high phase already in progress.
    assign clk_out = pos_q | neg_q;
`else
    assign clk_out = pos_q;
`endif

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time integer clock divider controller: start/stop FSM and the
// req/ack ratio-change handshake. Ratio changes take effect only at period
// boundaries so no runt pulses reach clk_out.
// Optional feature macro: CLK_DIV_CTRL_DUTY50_EN (50% duty for odd ratios).
module clk_div_ctrl #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 7
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             run_en,
    input  logic             div_req,
    input  logic [DIV_W-1:0] div_val,
    output logic             div_ack,
    output logic             div_err,
    output logic [DIV_W-1:0] div_cur,
    output logic             busy,
    output logic             clk_out,
    output logic             tick_out
);
    import clk_div_ctrl_pkg::*;

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(DIV_MIN);

    state_t           state_q;
    logic [DIV_W-1:0] div_cur_q;
    logic [DIV_W-1:0] pend_div_q;
    logic             ack_q;
    logic             err_q;
    logic             busy_q;

    logic             core_en;
    logic             wrap;
    logic             req_take;
    logic             req_bad;

    // A request is sampled only when no change is pending and we are not in
    // the ack cycle of the previous request (the requester still holds
    // div_req high while it sees the ack).
    assign req_take = div_req & ~ack_q & (state_q != PEND);
    assign req_bad  = (div_val < MIN_DIV);
    assign core_en  = (state_q != STOP);

    clk_div_core #(
        .DIV_W (DIV_W)
    ) u_core (
        .clk_in   (clk_in),
        .rst      (rst),
        .en       (core_en),
        .div      (div_cur_q),
        .clk_out  (clk_out),
        .tick_out (tick_out),
        .wrap     (wrap)
    );

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= STOP;
            div_cur_q  <= DEF_DIV;
            pend_div_q <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                STOP: begin
                    // Output is parked, so a valid ratio can be applied at once.
                    if (req_take) begin
                        ack_q <= 1'b1;
                        if (req_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            div_cur_q <= div_val;
                        end
                    end
                    if (run_en) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (wrap && !run_en) begin
                        // Stopping wins; any request is picked up next cycle in STOP.
                        state_q <= STOP;
                    end else if (req_take) begin
                        if (req_bad) begin
                            ack_q <= 1'b1;
                            err_q <= 1'b1;
                        end else begin
                            pend_div_q <= div_val;
                            busy_q     <= 1'b1;
                            state_q    <= PEND;
                        end
                    end
                end
                PEND: begin
                    // Old ratio runs to its boundary; the counter wraps to 0 there
                    // on its own, so the new ratio starts on a clean period.
                    if (wrap) begin
                        div_cur_q <= pend_div_q;
                        ack_q     <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= run_en ? RUN : STOP;
                    end
                end
                default: begin
                    state_q <= STOP;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign div_ack = ack_q;
    assign div_err = err_q;
    assign div_cur = div_cur_q;
    assign busy    = busy_q;

endmodule
